// File: rtl/complex_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// cmul_pkg
// Shared types, component indices and the round-robin pick function for
// complex_mul_arbiter.
// Revision: 1.0
// ============================================================================
package cmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam int REAL         = 0;
  localparam int IMAG         = 1;
  localparam int DEF_IN_BITS  = 37;
  localparam int DEF_OUT_BITS = 38;
  localparam int MAX_N        = 16;
  localparam int MAX_ID_W     = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
    logic [MAX_N-1:0]    onehot;
  } rr_pick_t;

  // First valid index scanning ptr+1, ptr+2, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]    valid,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t            pick;
    logic [MAX_ID_W-1:0] cand;
    pick = '0;
    cand = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n && !pick.found) begin
        cand = MAX_ID_W'((int'(ptr) + k) % n);
        if (valid[cand]) begin
          pick.found        = 1'b1;
          pick.idx          = cand;
          pick.onehot[cand] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/complex_fix_mul_clocked.sv
`default_nettype none
// ============================================================================
// complex_fix_mul_clocked
// Two-phase fixed-point complex multiplier: two real multipliers form ac/bd,
// then bc/ad; result is presented with a one-cycle 'available' strobe.
// Revision: 1.0
// ============================================================================
module complex_fix_mul_clocked
  import cmul_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic [2*IN_BITS-1:0]  x,
  input  logic [2*IN_BITS-1:0]  y,
  output logic                  available,
  output logic [2*OUT_BITS-1:0] out
);

  localparam int P_W = OUT_BITS - 1;

  logic signed [IN_BITS-1:0]   w_a, w_b, w_c, w_d;
  logic signed [IN_BITS-1:0]   w_m0_l, w_m1_l;
  logic signed [2*IN_BITS-1:0] w_full0, w_full1;
  logic signed [P_W-1:0]       w_p0, w_p1;
  logic signed [P_W-1:0]       r_ac, r_bd;
  logic signed [OUT_BITS-1:0]  w_re, w_im;
  logic                        r_ph1, r_ph2;
  logic                        w_unused_lsb;

  assign w_a = x[REAL*IN_BITS +: IN_BITS];
  assign w_b = x[IMAG*IN_BITS +: IN_BITS];
  assign w_c = y[REAL*IN_BITS +: IN_BITS];
  assign w_d = y[IMAG*IN_BITS +: IN_BITS];

  // Phase 1 forms ac and bd; phase 2 reuses the same multipliers for bc and ad.
  assign w_m0_l = r_ph1 ? w_a : w_b;
  assign w_m1_l = r_ph1 ? w_b : w_a;

  assign w_full0 = (2*IN_BITS)'(w_m0_l) * (2*IN_BITS)'(w_c);
  assign w_full1 = (2*IN_BITS)'(w_m1_l) * (2*IN_BITS)'(w_d);
  assign w_p0    = w_full0[2*IN_BITS-1 -: P_W];
  assign w_p1    = w_full1[2*IN_BITS-1 -: P_W];
  assign w_unused_lsb = ^{w_full0, w_full1};

  assign w_re = {r_ac[P_W-1], r_ac} - {r_bd[P_W-1], r_bd};
  assign w_im = {w_p0[P_W-1], w_p0} + {w_p1[P_W-1], w_p1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph1     <= 1'b0;
      r_ph2     <= 1'b0;
      available <= 1'b0;
      r_ac      <= '0;
      r_bd      <= '0;
      out       <= '0;
    end else begin
      r_ph1     <= ready;
      r_ph2     <= r_ph1;
      available <= r_ph2;
      if (r_ph1) begin
        r_ac <= w_p0;
        r_bd <= w_p1;
      end
      if (r_ph2) begin
        out[REAL*OUT_BITS +: OUT_BITS] <= w_re;
        out[IMAG*OUT_BITS +: OUT_BITS] <= w_im;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/complex_mul_arbiter.sv
`default_nettype none
// ============================================================================
// complex_mul_arbiter
// Round-robin sequencer sharing one two-phase complex multiplier among N
// requesters, with a one-entry id-tagged response buffer.
// Revision: 1.0
// ============================================================================
module complex_mul_arbiter
  import cmul_pkg::*;
#(
  parameter int  N        = 4,
  parameter int  IN_BITS  = DEF_IN_BITS,
  parameter int  OUT_BITS = DEF_OUT_BITS,
  localparam int ID_W     = (N > 2) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*2*IN_BITS-1:0] req_x,
  input  logic [N*2*IN_BITS-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*OUT_BITS-1:0]  rsp_data,
  output logic                   busy
);

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_ptr, r_id, w_win;
  logic [2*IN_BITS-1:0]  r_x, r_y;
  logic [MAX_N-1:0]      w_valid_ext;
  rr_pick_t              w_pick;
  logic                  w_grant, w_capture, w_mul_ready, w_mul_avail, w_mul_rst;
  logic [2*OUT_BITS-1:0] w_mul_out;
  logic                  w_unused_pick;

  always_comb begin
    w_valid_ext        = '0;
    w_valid_ext[N-1:0] = req_valid;
    w_pick             = rr_pick(w_valid_ext, MAX_ID_W'(r_ptr), N);
  end

  assign w_win         = ID_W'(w_pick.idx);
  assign w_unused_pick = ^w_pick;

  // Grant only into a free (or draining) buffer, so a capture never overwrites.
  assign w_grant     = reset && (r_state == IDLE) && w_pick.found && (!rsp_valid || rsp_ready);
  assign req_ready   = w_grant ? w_pick.onehot[N-1:0] : '0;
  assign w_mul_ready = (r_state == ISSUE);
  assign w_capture   = (r_state == BUSY) && w_mul_avail;
  assign busy        = (r_state != IDLE);
  assign w_mul_rst   = !reset;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = BUSY;
      BUSY:    if (w_mul_avail) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= ID_W'(N - 1);
      r_id    <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr <= w_win;
        r_id  <= w_win;
        r_x   <= req_x[w_win*2*IN_BITS +: 2*IN_BITS];
        r_y   <= req_y[w_win*2*IN_BITS +: 2*IN_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (w_capture) begin
      rsp_valid <= 1'b1;
      rsp_id    <= r_id;
      rsp_data  <= w_mul_out;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  complex_fix_mul_clocked #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_mul (
    .clk       (clk),
    .rst       (w_mul_rst),
    .ready     (w_mul_ready),
    .x         (r_x),
    .y         (r_y),
    .available (w_mul_avail),
    .out       (w_mul_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_complex_mul_arbiter.sv
`default_nettype none
// ============================================================================
// tb_complex_mul_arbiter
// Directed vectors with hand-computed products; a queue-based scoreboard
// checks every response handshake against the requester's expected result.
// Revision: 1.0
// ============================================================================
module tb_complex_mul_arbiter;

  localparam int N   = 4;
  localparam int IB  = 37;
  localparam int OB  = 38;
  localparam int OPW = 2*IB;
  localparam int RW  = 2*OB;

  localparam longint P28 = 64'sd1 <<< 28;
  localparam longint P29 = 64'sd1 <<< 29;
  localparam longint P30 = 64'sd1 <<< 30;
  localparam longint P31 = 64'sd1 <<< 31;
  localparam longint P33 = 64'sd1 <<< 33;
  localparam longint P34 = 64'sd1 <<< 34;
  localparam longint P35 = 64'sd1 <<< 35;
  localparam longint P36 = 64'sd1 <<< 36;

  logic             clk, reset;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*OPW-1:0] req_x, req_y;
  logic             rsp_valid, rsp_ready, busy;
  logic [1:0]       rsp_id;
  logic [RW-1:0]    rsp_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [RW+1:0] exp_q[$];

  // id, x.re, x.im, y.re, y.im, expected re, expected im (products >>> 37)
  longint tv [0:5][0:6] = '{
    '{1,    0,   0,    5,   -3,    0,      0},
    '{0,  P35,   0,  P30, -P31,  P28,   -P29},
    '{2,  P34, P33,  P34,  P34,  P30,  3*P30},
    '{3, -P35, P35,  P35,  P35, -P34,      0},
    '{1,   -1,   1,    1,    1,   -1,     -1},
    '{2, -P36,   0, -P36,    0,  P35,      0}
  };

  complex_mul_arbiter #(.N(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OPW-1:0] opnd(input longint re, input longint im);
    return {IB'(im), IB'(re)};
  endfunction

  function automatic logic [RW+1:0] expv(input longint id, input longint re, input longint im);
    return {2'(id), OB'(im), OB'(re)};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
      end else begin
        logic [RW+1:0] e;
        e = exp_q.pop_front();
        if ({rsp_id, rsp_data} !== e) begin
          bad++;
          $display("FAIL rsp_data: got id=%0d data=%h, required id=%0d data=%h",
                   rsp_id, rsp_data, e[RW+1:RW], e[RW-1:0]);
        end
      end
    end
    if (req_ready != '0) begin
      total++;
      if (!$onehot(req_ready)) begin
        bad++;
        $display("FAIL req_ready_onehot: got %b, required one-hot", req_ready);
      end
    end
  end

  task automatic send(input int id, input logic [OPW-1:0] x, input logic [OPW-1:0] y,
                      input logic [RW+1:0] e, input bit push, output int t_acc);
    req_x[id*OPW +: OPW] = x;
    req_y[id*OPW +: OPW] = y;
    req_valid[id] = 1'b1;
    t_acc = -1;
    for (int k = 0; k < 40 && t_acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        t_acc = cyc;
        if (push) exp_q.push_back(e);
      end
    end
    check($sformatf("accept_id%0d", id), t_acc >= 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic send_tv(input int i, input bit push);
    int t;
    send(int'(tv[i][0]), opnd(tv[i][1], tv[i][2]), opnd(tv[i][3], tv[i][4]),
         expv(tv[i][0], tv[i][5], tv[i][6]), push, t);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid && !busy) ok = 1'b1;
    end
    check("drain", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    #4;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int  t_prev;
    bit  got;
    reset     = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    req_valid = '0;
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Single op latency: rsp_valid exactly five cycles after accept.
    send_tv(0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("latency_rsp_valid_T+%0d", k), rsp_valid, (k == 5));
      check($sformatf("latency_busy_T+%0d", k), busy, (k < 5));
    end
    @(posedge clk); #1;
    for (int i = 1; i < 6; i++) send_tv(i, 1'b1);
    drain();

    // Round robin between requesters 0 and 2 from the reset pointer.
    pulse_reset();
    req_x[0*OPW +: OPW] = opnd(P35, 0);
    req_y[0*OPW +: OPW] = opnd(P30, -P31);
    req_x[2*OPW +: OPW] = opnd(P34, P33);
    req_y[2*OPW +: OPW] = opnd(P34, P34);
    req_valid = 4'b0101;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (req_ready != '0) got = 1'b1;
      end
      check($sformatf("rr_grant_%0d", i), req_ready, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      if (i > 0) check($sformatf("rr_spacing_%0d", i), cyc - t_prev, 5);
      t_prev = cyc;
      if (req_ready[0]) exp_q.push_back(expv(0, P28, -P29));
      if (req_ready[2]) exp_q.push_back(expv(2, P30, 3*P30));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // Backpressure: response held while requester 3 waits.
    rsp_ready = 1'b0;
    send_tv(1, 1'b1);
    req_x[3*OPW +: OPW] = opnd(-P35, P35);
    req_y[3*OPW +: OPW] = opnd(P35, P35);
    req_valid[3] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("bp_rsp_arrives", got, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 0);
      check("bp_rsp_data", rsp_data, expv(0, P28, -P29) & {2'b00, {RW{1'b1}}});
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_grant_on_release", req_ready, 4'b1000);
    if (req_ready[3]) exp_q.push_back(expv(3, -P34, 0));
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Operand hold: requester scribbles on its inputs after accept.
    send_tv(2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      req_x[2*OPW +: OPW] = OPW'({$urandom(), $urandom(), $urandom()});
      req_y[2*OPW +: OPW] = OPW'({$urandom(), $urandom(), $urandom()});
      @(posedge clk); #1;
    end
    drain();

    // Reset mid-op: in-flight op dropped, first grant goes to requester 0.
    send_tv(4, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_busy", busy, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    req_x[0*OPW +: OPW] = opnd(-1, 1);
    req_y[0*OPW +: OPW] = opnd(1, 1);
    req_x[1*OPW +: OPW] = opnd(P35, 0);
    req_y[1*OPW +: OPW] = opnd(P30, -P31);
    req_x[3*OPW +: OPW] = opnd(P34, P33);
    req_y[3*OPW +: OPW] = opnd(P34, P34);
    req_valid = 4'b1011;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check("midreset_first_grant", req_ready, 4'b0001);
    if (req_ready[0]) exp_q.push_back(expv(0, -1, -1));
    if (req_ready[1]) exp_q.push_back(expv(1, P28, -P29));
    if (req_ready[3]) exp_q.push_back(expv(3, P30, 3*P30));
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
